// File: rtl/slice_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are summed SLICE bits per clock,
// LSB first, with the ripple carry held in a register between cycles.
module slice_adder #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Carry,
    output logic             Overflow
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             sub_q, sub_d;
    logic             signed_q, signed_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0] slice_a, slice_b;
    logic [SLICE:0]   slice_res;
    logic             msb_cin;
    int               lsb;

    // The carry into the slice's top bit is recovered from its sum bit, which
    // gives the true carry into bit WIDTH-1 on the final slice.
    always_comb begin
        lsb       = SLICE * int'(cnt_q);
        slice_a   = op_a_q[lsb +: SLICE];
        slice_b   = op_b_q[lsb +: SLICE];
        slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, cin_q};
        msb_cin   = slice_res[SLICE-1] ^ slice_a[SLICE-1] ^ slice_b[SLICE-1];
    end

    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        work_d   = work_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        cin_d    = cin_q;
        sub_d    = sub_q;
        signed_d = signed_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d  = RUN;
                    op_a_d   = A;
                    op_b_d   = Sub ? ~B : B;
                    cin_d    = Sub;
                    sub_d    = Sub;
                    signed_d = Signed;
                    cnt_d    = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                work_d[lsb +: SLICE] = slice_res[SLICE-1:0];
                cin_d                = slice_res[SLICE];
                cnt_d                = cnt_q + CW'(1);
                // Results are published only as the last slice completes.
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = work_d;
                    carry_d = slice_res[SLICE];
                    if (signed_q)
                        ovf_d = msb_cin ^ slice_res[SLICE];
                    else
                        ovf_d = sub_q ? ~slice_res[SLICE] : slice_res[SLICE];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            work_q   <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
            sub_q    <= 1'b0;
            signed_q <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            work_q   <= work_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            cin_q    <= cin_d;
            sub_q    <= sub_d;
            signed_q <= signed_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy     = (state_q == RUN);
    assign Done     = (state_q == DONE);
    assign Sum      = sum_q;
    assign Carry    = carry_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_slice_adder.sv
// Bench for slice_adder: three instances (32/8, 8/8, 8/1) checked against an
// arithmetic reference model with directed and random operations.
module tb_slice_adder;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_32, start_8a, start_8b;
    logic        sub_in, sgn_in;
    logic [31:0] a_in, b_in;

    logic        busy32, done32, carry32, ovf32;
    logic [31:0] sum32;
    logic        busy8a, done8a, carry8a, ovf8a;
    logic [7:0]  sum8a;
    logic        busy8b, done8b, carry8b, ovf8b;
    logic [7:0]  sum8b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    slice_adder #(.WIDTH(32), .SLICE(8)) dut32 (
        .Clk(clk), .Reset(reset), .Start(start_32), .Sub(sub_in), .Signed(sgn_in),
        .A(a_in), .B(b_in), .Busy(busy32), .Done(done32), .Sum(sum32),
        .Carry(carry32), .Overflow(ovf32)
    );

    slice_adder #(.WIDTH(8), .SLICE(8)) dut8a (
        .Clk(clk), .Reset(reset), .Start(start_8a), .Sub(sub_in), .Signed(sgn_in),
        .A(a_in[7:0]), .B(b_in[7:0]), .Busy(busy8a), .Done(done8a), .Sum(sum8a),
        .Carry(carry8a), .Overflow(ovf8a)
    );

    slice_adder #(.WIDTH(8), .SLICE(1)) dut8b (
        .Clk(clk), .Reset(reset), .Start(start_8b), .Sub(sub_in), .Signed(sgn_in),
        .A(a_in[7:0]), .B(b_in[7:0]), .Busy(busy8b), .Done(done8b), .Sum(sum8b),
        .Carry(carry8b), .Overflow(ovf8b)
    );

    // Reference result from plain integer arithmetic on w-bit values.
    function automatic res_t refModel(input logic [31:0] a, input logic [31:0] b,
                                      input logic sub, input logic sgn, input int w);
        longint unsigned mask, ua, ub, tot;
        longint          sa, sb, r, lim;
        res_t            res;
        mask = (64'd1 << w) - 64'd1;
        ua   = 64'(a) & mask;
        ub   = 64'(b) & mask;
        tot  = sub ? (ua - ub) : (ua + ub);
        res.sum   = 32'(tot & mask);
        res.carry = sub ? (ua >= ub) : (((tot >> w) & 64'd1) != 64'd0);
        lim = longint'(64'd1 << (w - 1));
        sa  = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
        sb  = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
        r   = sub ? (sa - sb) : (sa + sb);
        if (sgn)
            res.ovf = (r >= lim) || (r < -lim);
        else
            res.ovf = sub ? (ua < ub) : res.carry;
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Runs one operation on all three instances and checks timing and results.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic sub, input logic sgn);
        int   busy_n[3];
        int   done_n[3];
        int   done_k[3];
        res_t e32, e8;
        string id;
        for (int i = 0; i < 3; i++) begin
            busy_n[i] = 0;
            done_n[i] = 0;
            done_k[i] = -1;
        end
        @(negedge clk);
        a_in = a; b_in = b; sub_in = sub; sgn_in = sgn;
        start_32 = 1'b1; start_8a = 1'b1; start_8b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_32 = 1'b0; start_8a = 1'b0; start_8b = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (busy32) busy_n[0]++;
            if (busy8a) busy_n[1]++;
            if (busy8b) busy_n[2]++;
            if (done32) begin done_n[0]++; done_k[0] = k; end
            if (done8a) begin done_n[1]++; done_k[1] = k; end
            if (done8b) begin done_n[2]++; done_k[2] = k; end
        end
        e32 = refModel(a, b, sub, sgn, 32);
        e8  = refModel(a, b, sub, sgn, 8);
        id  = $sformatf("a=%h b=%h s=%0d g=%0d", a, b, sub, sgn);
        checkOutput({"busy_cycles_32 ", id}, busy_n[0], 4);
        checkOutput({"busy_cycles_8x8 ", id}, busy_n[1], 1);
        checkOutput({"busy_cycles_8x1 ", id}, busy_n[2], 8);
        checkOutput({"done_edge_32 ", id}, done_k[0], 4);
        checkOutput({"done_edge_8x8 ", id}, done_k[1], 1);
        checkOutput({"done_edge_8x1 ", id}, done_k[2], 8);
        checkOutput({"done_pulses ", id}, {done_n[0][7:0], done_n[1][7:0], done_n[2][7:0]}, 32'h010101);
        checkOutput({"sum_32 ", id}, sum32, e32.sum);
        checkOutput({"carry_32 ", id}, 32'(carry32), 32'(e32.carry));
        checkOutput({"ovf_32 ", id}, 32'(ovf32), 32'(e32.ovf));
        checkOutput({"sum_8x8 ", id}, 32'(sum8a), e8.sum);
        checkOutput({"flags_8x8 ", id}, {30'd0, carry8a, ovf8a}, {30'd0, e8.carry, e8.ovf});
        checkOutput({"sum_8x1 ", id}, 32'(sum8b), e8.sum);
        checkOutput({"flags_8x1 ", id}, {30'd0, carry8b, ovf8b}, {30'd0, e8.carry, e8.ovf});
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_ctrl32"}, {30'd0, busy32, done32}, 32'd0);
        checkOutput({tag, "_sum32"}, sum32, 32'd0);
        checkOutput({tag, "_flags32"}, {30'd0, carry32, ovf32}, 32'd0);
        checkOutput({tag, "_all8"}, {busy8a, done8a, carry8a, ovf8a, busy8b, done8b, carry8b, ovf8b,
                                     sum8a, sum8b}, 32'd0);
    endtask

    initial begin
        int t_first, t_second, seen;
        reset = 1'b1;
        start_32 = 1'b0; start_8a = 1'b0; start_8b = 1'b0;
        sub_in = 1'b0; sgn_in = 1'b0; a_in = '0; b_in = '0;

        // Reset held two cycles, then idle with no Start.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkIdleZero($sformatf("reset_c%0d", i));
        end
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkIdleZero($sformatf("idle_c%0d", i));
        end

        applyStimulus(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        applyStimulus(32'h8000_0000, 32'h1, 1'b1, 1'b1);
        applyStimulus(32'h8000_0000, 32'h1, 1'b1, 1'b0);
        applyStimulus(32'h0000_007F, 32'h1, 1'b0, 1'b1);
        applyStimulus(32'h0000_00AA, 32'h55, 1'b0, 1'b0);
        applyStimulus(32'h0000_0003, 32'h5, 1'b1, 1'b0);

        // Back-to-back Start in DONE, plus a Start mid-RUN that must be ignored.
        @(negedge clk);
        a_in = 32'h8000_0000; b_in = 32'h1; sub_in = 1'b1; sgn_in = 1'b1; start_32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_32 = 1'b0;
        for (int k = 0; k < 10 && done32 !== 1'b1; k++) @(negedge clk);
        t_first = cyc;
        checkOutput("b2b_first_done", 32'(done32), 32'd1);
        checkOutput("b2b_first_sum", sum32, 32'h7FFF_FFFF);
        a_in = 32'd5; b_in = 32'd3; sub_in = 1'b1; sgn_in = 1'b0; start_32 = 1'b1;
        @(negedge clk);
        start_32 = 1'b0;
        checkOutput("b2b_busy_after_restart", {30'd0, busy32, done32}, 32'b10);
        @(negedge clk);
        @(negedge clk);
        checkOutput("b2b_sum_held_in_run", sum32, 32'h7FFF_FFFF);
        a_in = 32'd9; b_in = 32'd0; sub_in = 1'b0; start_32 = 1'b1;
        @(negedge clk);
        start_32 = 1'b0;
        for (int k = 0; k < 10 && done32 !== 1'b1; k++) @(negedge clk);
        t_second = cyc;
        checkOutput("b2b_second_done", 32'(done32), 32'd1);
        checkOutput("b2b_second_sum", sum32, 32'd2);
        checkOutput("b2b_throughput", t_second - t_first, 32'd5);
        for (int i = 0; i < 3; i++) @(negedge clk);
        checkOutput("ignored_start_no_run", {30'd0, busy32, done32}, 32'd0);
        checkOutput("ignored_start_sum", sum32, 32'd2);

        // Reset two cycles into RUN abandons the operation.
        @(negedge clk);
        a_in = 32'h1234_5678; b_in = 32'h1; sub_in = 1'b0; sgn_in = 1'b0; start_32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_32 = 1'b0;
        seen = 0;
        @(negedge clk);
        if (done32) seen++;
        @(negedge clk);
        if (done32) seen++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkIdleZero("reset_mid_run");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done32) seen++;
        end
        checkOutput("reset_mid_run_no_done", seen, 32'd0);
        checkOutput("reset_mid_run_sum_zero", sum32, 32'd0);
        applyStimulus(32'h1234_5678, 32'h1, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
